// File: rtl/frame_swap_controller_if.sv
// Engine <-> frame store bus for frame_swap_controller: column writes, commit
// handshake, swap status and the front-buffer planes fed to the blit panel.
interface frame_swap_controller_if #(
  parameter int FRAME_WIDTH  = 10,
  parameter int FRAME_HEIGHT = 20,
  parameter int COL_BITS     = 4,
  parameter int COUNT_WIDTH  = 16
);
  logic                                     wr_en;
  logic [COL_BITS-1:0]                      wr_col;
  logic [FRAME_HEIGHT-1:0]                  wr_data_R;
  logic [FRAME_HEIGHT-1:0]                  wr_data_G;
  logic [FRAME_HEIGHT-1:0]                  wr_data_B;
  logic                                     wr_ready;
  logic                                     commit_valid;
  logic                                     commit_ready;
  logic                                     swap_pending;
  logic                                     swap_done;
  logic [COUNT_WIDTH-1:0]                   frame_count;
  logic [FRAME_WIDTH-1:0][FRAME_HEIGHT-1:0] frame_R;
  logic [FRAME_WIDTH-1:0][FRAME_HEIGHT-1:0] frame_G;
  logic [FRAME_WIDTH-1:0][FRAME_HEIGHT-1:0] frame_B;

  modport master (
    output wr_en, wr_col, wr_data_R, wr_data_G, wr_data_B, commit_valid,
    input  wr_ready, commit_ready, swap_pending, swap_done, frame_count,
           frame_R, frame_G, frame_B
  );

  modport slave (
    input  wr_en, wr_col, wr_data_R, wr_data_G, wr_data_B, commit_valid,
    output wr_ready, commit_ready, swap_pending, swap_done, frame_count,
           frame_R, frame_G, frame_B
  );
endinterface

// File: rtl/frame_swap_controller.sv
// Double-buffered frame store: back buffer is copied to front on the first vblank
// rising edge after a commit. Define FRAME_SWAP_CLEAR_EN to blank the back buffer on swap.
//
// state   | meaning
// IDLE    | writes and commits accepted
// PENDING | commit held, waiting for a fresh vblank rise
// SWAP    | front just loaded; swap_done pulse, frame_count bump
module frame_swap_controller #(
  parameter int FRAME_WIDTH  = 10,
  parameter int FRAME_HEIGHT = 20,
  parameter int COL_BITS     = 4,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      vblank,
  frame_swap_controller_if.slave    bus
);

  typedef logic [FRAME_WIDTH-1:0][FRAME_HEIGHT-1:0] plane_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SWAP    = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic                   vblank_q;
  plane_t                 back_r_q, back_r_d, back_g_q, back_g_d, back_b_q, back_b_d;
  plane_t                 front_r_q, front_r_d, front_g_q, front_g_d, front_b_q, front_b_d;
  logic [COUNT_WIDTH-1:0] frame_count_q, frame_count_d;

  logic vblank_rise;
  logic enter_swap;
  logic wr_ready;
  logic commit_ready;
  logic swap_pending;
  logic swap_done;

  assign vblank_rise = vblank & ~vblank_q;

  always_comb begin
    state_d      = state_q;
    wr_ready     = 1'b0;
    commit_ready = 1'b0;
    swap_pending = 1'b0;
    swap_done    = 1'b0;
    enter_swap   = 1'b0;
    case (state_q)
      IDLE: begin
        wr_ready     = 1'b1;
        commit_ready = 1'b1;
        if (bus.commit_valid) state_d = PENDING;
      end
      PENDING: begin
        swap_pending = 1'b1;
        // Only PENDING looks at the edge, so a rise in the accepting cycle is skipped.
        if (vblank_rise) begin
          state_d    = SWAP;
          enter_swap = 1'b1;
        end
      end
      SWAP: begin
        swap_done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    back_r_d      = back_r_q;
    back_g_d      = back_g_q;
    back_b_d      = back_b_q;
    front_r_d     = front_r_q;
    front_g_d     = front_g_q;
    front_b_d     = front_b_q;
    frame_count_d = frame_count_q;

    if (bus.wr_en && wr_ready) begin
      for (int c = 0; c < FRAME_WIDTH; c++) begin
        if (bus.wr_col == COL_BITS'(c)) begin
          back_r_d[c] = bus.wr_data_R;
          back_g_d[c] = bus.wr_data_G;
          back_b_d[c] = bus.wr_data_B;
        end
      end
    end

    if (enter_swap) begin
      front_r_d = back_r_q;
      front_g_d = back_g_q;
      front_b_d = back_b_q;
`ifdef FRAME_SWAP_CLEAR_EN
      back_r_d  = '0;
      back_g_d  = '0;
      back_b_d  = '0;
`else
      back_r_d  = back_r_q;
      back_g_d  = back_g_q;
      back_b_d  = back_b_q;
`endif
    end

    if (state_q == SWAP) frame_count_d = frame_count_q + 1'b1;
  end

  // vblank_q resets high so a reset released inside vblank cannot look like a rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      vblank_q      <= 1'b1;
      back_r_q      <= '0;
      back_g_q      <= '0;
      back_b_q      <= '0;
      front_r_q     <= '0;
      front_g_q     <= '0;
      front_b_q     <= '0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      vblank_q      <= vblank;
      back_r_q      <= back_r_d;
      back_g_q      <= back_g_d;
      back_b_q      <= back_b_d;
      front_r_q     <= front_r_d;
      front_g_q     <= front_g_d;
      front_b_q     <= front_b_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign bus.wr_ready     = wr_ready;
  assign bus.commit_ready = commit_ready;
  assign bus.swap_pending = swap_pending;
  assign bus.swap_done    = swap_done;
  assign bus.frame_count  = frame_count_q;
  assign bus.frame_R      = front_r_q;
  assign bus.frame_G      = front_g_q;
  assign bus.frame_B      = front_b_q;

endmodule

// File: tb/tb_frame_swap_controller.sv
// Scenario bench for frame_swap_controller: expected front frames are queued at commit
// time from a bench-side buffer model and popped when swap_done fires.
module tb_frame_swap_controller;
  localparam int W  = 10;
  localparam int H  = 20;
  localparam int CB = 4;
  localparam int CW = 16;

  typedef logic [W-1:0][H-1:0] plane_t;
  typedef struct {
    plane_t          r;
    plane_t          g;
    plane_t          b;
    logic [CW-1:0]   cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic vblank;

  frame_swap_controller_if #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H), .COL_BITS(CB), .COUNT_WIDTH(CW)) bus ();

  frame_swap_controller #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H), .COL_BITS(CB), .COUNT_WIDTH(CW)) dut (
    .clk    (clk),
    .reset  (reset),
    .vblank (vblank),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  exp_t          sb[$];
  plane_t        mb_r, mb_g, mb_b;
  logic [CW-1:0] m_cnt;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    mb_r  = '0;
    mb_g  = '0;
    mb_b  = '0;
    m_cnt = '0;
  endtask

  task automatic model_write(input logic [CB-1:0] col, input logic [H-1:0] r, input logic [H-1:0] g,
                             input logic [H-1:0] b);
    if (int'(col) < W) begin
      mb_r[col] = r;
      mb_g[col] = g;
      mb_b[col] = b;
    end
  endtask

  task automatic model_commit();
    exp_t e;
    e.r   = mb_r;
    e.g   = mb_g;
    e.b   = mb_b;
    m_cnt = m_cnt + 1'b1;
    e.cnt = m_cnt;
    sb.push_back(e);
`ifdef FRAME_SWAP_CLEAR_EN
    mb_r = '0;
    mb_g = '0;
    mb_b = '0;
`endif
  endtask

  task automatic drive(input logic wen, input logic [CB-1:0] col, input logic [H-1:0] r,
                       input logic [H-1:0] g, input logic [H-1:0] b, input logic cval);
    bus.wr_en        = wen;
    bus.wr_col       = col;
    bus.wr_data_R    = r;
    bus.wr_data_G    = g;
    bus.wr_data_B    = b;
    bus.commit_valid = cval;
    step();
    bus.wr_en        = 1'b0;
    bus.commit_valid = 1'b0;
  endtask

  task automatic commit_idle(input string name);
    vectors++;
    if (bus.commit_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s commit_ready got %b exp 1", name, bus.commit_ready);
    end
    drive(1'b0, '0, '0, '0, '0, 1'b1);
    model_commit();
    vectors++;
    if (bus.swap_pending !== 1'b1) begin
      miscompares++;
      $display("FAIL %s swap_pending got %b exp 1", name, bus.swap_pending);
    end
  endtask

  task automatic vblank_pulse();
    vblank = 1'b0;
    step();
    vblank = 1'b1;
    step();
  endtask

  task automatic wait_swap(input string name);
    exp_t e;
    bit   seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (bus.swap_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL %s swap_done timeout got 0 exp 1", name);
      return;
    end
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL %s swap_done got unexpected pulse exp none", name);
      return;
    end
    e = sb.pop_front();
    vectors++;
    if (bus.frame_R !== e.r) begin
      miscompares++;
      $display("FAIL %s frame_R got %h exp %h", name, bus.frame_R, e.r);
    end
    vectors++;
    if (bus.frame_G !== e.g) begin
      miscompares++;
      $display("FAIL %s frame_G got %h exp %h", name, bus.frame_G, e.g);
    end
    vectors++;
    if (bus.frame_B !== e.b) begin
      miscompares++;
      $display("FAIL %s frame_B got %h exp %h", name, bus.frame_B, e.b);
    end
    step();
    vectors++;
    if (bus.swap_done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s swap_done width got %b exp 0", name, bus.swap_done);
    end
    vectors++;
    if (bus.frame_count !== e.cnt) begin
      miscompares++;
      $display("FAIL %s frame_count got %0d exp %0d", name, bus.frame_count, e.cnt);
    end
  endtask

  task automatic test_reset();
    reset            = 1'b1;
    vblank           = 1'b1;
    bus.wr_en        = 1'b0;
    bus.wr_col       = '0;
    bus.wr_data_R    = '0;
    bus.wr_data_G    = '0;
    bus.wr_data_B    = '0;
    bus.commit_valid = 1'b0;
    model_clear();
    repeat (3) step();
    reset = 1'b0;
    step();
    vectors++;
    if (bus.frame_R !== '0 || bus.frame_G !== '0 || bus.frame_B !== '0) begin
      miscompares++;
      $display("FAIL reset frames got %h/%h/%h exp 0", bus.frame_R, bus.frame_G, bus.frame_B);
    end
    vectors++;
    if ({bus.wr_ready, bus.commit_ready, bus.swap_pending, bus.swap_done} !== 4'b1100) begin
      miscompares++;
      $display("FAIL reset status got %b%b%b%b exp 1100", bus.wr_ready, bus.commit_ready,
               bus.swap_pending, bus.swap_done);
    end
    vectors++;
    if (bus.frame_count !== '0) begin
      miscompares++;
      $display("FAIL reset frame_count got %0d exp 0", bus.frame_count);
    end
  endtask

  task automatic test_basic_swap();
    drive(1'b1, 4'd3, 20'h00F0F, 20'h12345, 20'h0ABCD, 1'b0);
    model_write(4'd3, 20'h00F0F, 20'h12345, 20'h0ABCD);
    commit_idle("basic");
    vectors++;
    if (bus.frame_R !== '0) begin
      miscompares++;
      $display("FAIL basic early_front got %h exp 0", bus.frame_R);
    end
    vblank_pulse();
    vectors++;
    if (bus.frame_R[3] !== 20'h00F0F) begin
      miscompares++;
      $display("FAIL basic frame_R3 got %h exp 00f0f", bus.frame_R[3]);
    end
    wait_swap("basic");
  endtask

  task automatic test_pending_drop();
    commit_idle("drop");
    vectors++;
    if (bus.wr_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL drop wr_ready got %b exp 0", bus.wr_ready);
    end
    drive(1'b1, 4'd2, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 1'b0);
    vblank_pulse();
    wait_swap("drop");
  endtask

  task automatic test_commit_on_rise();
    bit early = 1'b0;
    vblank = 1'b0;
    step();
    vblank = 1'b1;
    drive(1'b1, 4'd7, 20'hA5A5A, 20'h5A5A5, 20'h0F00F, 1'b1);
    model_write(4'd7, 20'hA5A5A, 20'h5A5A5, 20'h0F00F);
    model_commit();
    for (int n = 0; n < 4; n++) begin
      if (bus.swap_done !== 1'b0 || bus.swap_pending !== 1'b1) early = 1'b1;
      step();
    end
    vectors++;
    if (early) begin
      miscompares++;
      $display("FAIL rise_commit early_swap got swap on accepting edge exp wait");
    end
    vblank_pulse();
    wait_swap("rise_commit");
  endtask

  task automatic test_bad_col();
    drive(1'b1, 4'd15, 20'h13579, 20'h2468A, 20'hFEDCB, 1'b0);
    model_write(4'd15, 20'h13579, 20'h2468A, 20'hFEDCB);
    commit_idle("bad_col");
    vblank_pulse();
    wait_swap("bad_col");
  endtask

  task automatic test_reset_pending();
    bit stray = 1'b0;
    drive(1'b1, 4'd4, 20'h77777, 20'h88888, 20'h99999, 1'b0);
    drive(1'b0, '0, '0, '0, '0, 1'b1);
    vectors++;
    if (bus.swap_pending !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_pend swap_pending got %b exp 1", bus.swap_pending);
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (bus.swap_pending !== 1'b0 || bus.wr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_pend state got pend=%b rdy=%b exp 0/1", bus.swap_pending, bus.wr_ready);
    end
    vectors++;
    if (bus.frame_R !== '0 || bus.frame_G !== '0 || bus.frame_B !== '0 || bus.frame_count !== '0) begin
      miscompares++;
      $display("FAIL rst_pend front got %h cnt %0d exp 0", bus.frame_R, bus.frame_count);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    model_clear();
    vblank = 1'b0;
    for (int n = 0; n < 4; n++) begin
      if (bus.swap_done !== 1'b0) stray = 1'b1;
      vblank = ~vblank;
      step();
    end
    vectors++;
    if (stray) begin
      miscompares++;
      $display("FAIL rst_pend swap_done got pulse exp none");
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 4'd5, 20'hC3C3C, 20'h3C3C3, 20'h00001, 1'b0);
    model_write(4'd5, 20'hC3C3C, 20'h3C3C3, 20'h00001);
    commit_idle("b2b_1");
    vblank_pulse();
    wait_swap("b2b_1");
    commit_idle("b2b_2");
    vblank_pulse();
    wait_swap("b2b_2");
  endtask

  initial begin
    test_reset();
    test_basic_swap();
    test_pending_drop();
    test_commit_on_rise();
    test_bad_col();
    test_reset_pending();
    test_back_to_back();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard leftover got %0d exp 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
